// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
package pipe_pkg;

    // Bubble encoding driven on invalid or flushed lanes.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Occupancy states; the encoding doubles as the entry count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Reference bundle layout for the default single-lane, 32-bit configuration.
    localparam int unsigned BUNDLE_AW    = 32;
    localparam int unsigned BUNDLE_IW    = 32;
    localparam int unsigned BUNDLE_LANES = 1;

    typedef struct packed {
        logic [BUNDLE_LANES*BUNDLE_IW-1:0] instn;
        logic [BUNDLE_LANES-1:0]           lane_mask;
        logic [BUNDLE_AW-1:0]              pc;
        logic [BUNDLE_AW-1:0]              pc_plus4;
    } bundle_t;

    // Packed width of a bundle {instn, lane_mask, pc, pc_plus4}.
    function automatic int unsigned bundle_width(input int unsigned aw, input int unsigned iw,
                                                 input int unsigned lanes);
        return lanes * iw + lanes + 2 * aw;
    endfunction

endpackage

// File: rtl/pipe_skid_buf2.sv
// Generic 2-entry skid FIFO: MAIN drives the output, SKID absorbs one overflow beat.
// o_ready and o_valid are flops, so no input reaches o_ready combinationally.
module pipe_skid_buf2
    import pipe_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output occ_e         o_occ
);

    occ_e         r_state;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         r_ready;
    logic         r_valid;
    logic         w_push;
    logic         w_pop;

    assign w_push = i_push && r_ready;
    assign w_pop  = i_pop && r_valid;

    // Occupancy FSM with data movement; clear returns to the reset pattern.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= OCC_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_state <= OCC_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_push) begin
                        r_main  <= i_data;
                        r_state <= OCC_ONE;
                        r_valid <= 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (w_push && w_pop) begin
                        r_main <= i_data;
                    end else if (w_push) begin
                        r_skid  <= i_data;
                        r_state <= OCC_FULL;
                        r_ready <= 1'b0;
                    end else if (w_pop) begin
                        r_state <= OCC_EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                OCC_FULL: begin
                    // r_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_state <= OCC_ONE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= OCC_EMPTY;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_main;
    assign o_occ   = r_state;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: skid-buffered bundle transfer with stall gating,
// flush-to-bubble, lane NOP masking and a saturating flush counter.
module if_id_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned    AW    = 32,
    parameter int unsigned    IW    = 32,
    parameter int unsigned    LANES = 1,
    parameter logic [IW-1:0]  NOP   = IW'(NOP_INSTR),
    parameter int unsigned    CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IW-1:0]   in_instn,
    input  logic [LANES-1:0]      in_lane_mask,
    input  logic [AW-1:0]         in_pc,
    input  logic [AW-1:0]         in_pc_plus4,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*IW-1:0]   out_instn,
    output logic [LANES-1:0]      out_lane_mask,
    output logic [AW-1:0]         out_pc,
    output logic [AW-1:0]         out_pc_plus4,
    output logic [1:0]            occupancy,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int unsigned BW = bundle_width(AW, IW, LANES);
    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic [BW-1:0]        w_in_bundle;
    logic [BW-1:0]        w_main;
    logic                 w_valid;
    logic                 w_pop;
    occ_e                 w_occ;
    logic [LANES*IW-1:0]  w_main_instn;
    logic [LANES-1:0]     w_main_mask;
    logic [CNT_W+1:0]     w_cnt_sum;
    logic [CNT_W-1:0]     r_flush_cnt;

    assign w_in_bundle = {in_instn, in_lane_mask, in_pc, in_pc_plus4};
    // A stalled ID stage looks exactly like out_ready low.
    assign w_pop       = out_ready && !stall;

    pipe_skid_buf2 #(
        .W(BW)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (flush),
        .i_push (in_valid),
        .i_data (w_in_bundle),
        .o_ready(in_ready),
        .i_pop  (w_pop),
        .o_valid(w_valid),
        .o_data (w_main),
        .o_occ  (w_occ)
    );

    assign w_main_instn  = w_main[BW-1 -: LANES*IW];
    assign w_main_mask   = w_main[2*AW +: LANES];
    assign out_pc        = w_main[AW +: AW];
    assign out_pc_plus4  = w_main[AW-1:0];
    assign out_valid     = w_valid;
    assign out_lane_mask = w_valid ? w_main_mask : '0;
    assign occupancy     = w_occ;

    // Force NOP onto lanes that are masked off or when nothing is presented.
    always_comb begin
        out_instn = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            out_instn[l*IW +: IW] = (w_valid && w_main_mask[l]) ? w_main_instn[l*IW +: IW] : NOP;
        end
    end

    // Entries discarded by a flush are the held occupancy at the flush edge.
    assign w_cnt_sum = {2'b00, r_flush_cnt} + {{CNT_W{1'b0}}, occupancy};

    // Saturating count of valid bundles dropped by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flush_cnt <= '0;
        end else if (flush) begin
            r_flush_cnt <= (w_cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : w_cnt_sum[CNT_W-1:0];
        end
    end

    assign flush_cnt = r_flush_cnt;

endmodule
